// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution.
// It holds one decoded execute bundle for the memory stage. When a taken,
// aligned control transfer is accepted, it raises redirect_valid for one
// cycle, and it squashes the wrong-path bundle offered during that cycle.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic                      in_alu_zero,
  input  logic [6:0]                in_opcode,
  input  logic [2:0]                in_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_reg_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [2:0]                out_funct3,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_mem_read,
  output logic                      out_mem_write,
  output logic                      out_misaligned,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic                      r_out_valid;
  logic [DATA_WIDTH-1:0]     r_out_result;
  logic [DATA_WIDTH-1:0]     r_out_store_data;
  logic [2:0]                r_out_funct3;
  logic [REG_ADDR_WIDTH-1:0] r_out_rd;
  logic                      r_out_reg_write;
  logic                      r_out_mem_read;
  logic                      r_out_mem_write;
  logic                      r_out_misaligned;
  logic                      r_redirect_valid;
  logic [DATA_WIDTH-1:0]     r_redirect_pc;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_is_branch;
  logic                      w_is_jal;
  logic                      w_is_jalr;
  logic                      w_is_load;
  logic                      w_is_store;
  logic                      w_taken;
  logic [DATA_WIDTH-1:0]     w_target;
  logic                      w_misaligned;
  logic                      w_redirect;
  logic                      w_reg_write;
  logic [DATA_WIDTH-1:0]     w_result;

  assign w_in_ready = !r_out_valid || out_ready;
  // A bundle offered while a redirect is being issued is on the wrong path.
  // It is dropped, and the held entry is left alone.
  assign w_accept   = in_valid && w_in_ready && !r_redirect_valid;

  // Decode the incoming bundle and resolve the control transfer it carries.
  always_comb begin
    w_is_branch  = (in_opcode == OP_BRANCH);
    w_is_jal     = (in_opcode == OP_JAL);
    w_is_jalr    = (in_opcode == OP_JALR);
    w_is_load    = (in_opcode == OP_LOAD);
    w_is_store   = (in_opcode == OP_STORE);
    w_taken      = (w_is_branch && in_alu_zero) || w_is_jal || w_is_jalr;
    w_target     = in_pc + in_imm;
    if (w_is_jalr) begin
      w_target = {in_alu_result[DATA_WIDTH-1:1], 1'b0};
    end
    w_misaligned = w_taken && (w_target[1:0] != 2'b00);
    w_redirect   = w_taken && !w_misaligned;
    w_result     = in_alu_result;
    if (w_is_jal || w_is_jalr) begin
      w_result = in_pc + DATA_WIDTH'(4);
    end
    w_reg_write  = in_reg_write && (in_rd != '0) && !w_is_branch
                   && !w_is_store && !w_misaligned;
  end

  // Pipeline register: load on accept, empty on drain, otherwise hold.
  // The redirect register is loaded only when a bundle is accepted, so a
  // stalled entry cannot raise redirect_valid a second time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_out_result     <= '0;
      r_out_store_data <= '0;
      r_out_funct3     <= '0;
      r_out_rd         <= '0;
      r_out_reg_write  <= 1'b0;
      r_out_mem_read   <= 1'b0;
      r_out_mem_write  <= 1'b0;
      r_out_misaligned <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_accept && w_redirect;
      if (w_accept) begin
        r_out_valid      <= 1'b1;
        r_out_result     <= w_result;
        r_out_store_data <= in_rs2_data;
        r_out_funct3     <= in_funct3;
        r_out_rd         <= in_rd;
        r_out_reg_write  <= w_reg_write;
        r_out_mem_read   <= w_is_load;
        r_out_mem_write  <= w_is_store;
        r_out_misaligned <= w_misaligned;
        if (w_taken) begin
          r_redirect_pc <= w_target;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_store_data = r_out_store_data;
  assign out_funct3     = r_out_funct3;
  assign out_rd         = r_out_rd;
  assign out_reg_write  = r_out_reg_write;
  assign out_mem_read   = r_out_mem_read;
  assign out_mem_write  = r_out_mem_write;
  assign out_misaligned = r_out_misaligned;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage: hand-computed expected values,
// with a single checking task.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [31:0] in_alu_result;
  logic [31:0] in_rs2_data;
  logic        in_alu_zero;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_misaligned;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checkCount;
  int errorCount;

  ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_alu_zero(in_alu_zero), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_funct3(out_funct3), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_misaligned(out_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [6:0] opcode,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] alu, input logic zero,
                               input logic [31:0] rs2, input logic [2:0] f3,
                               input logic [4:0] rd, input logic rw);
    in_valid      = valid;
    in_opcode     = opcode;
    in_pc         = pc;
    in_imm        = imm;
    in_alu_result = alu;
    in_alu_zero   = zero;
    in_rs2_data   = rs2;
    in_funct3     = f3;
    in_rd         = rd;
    in_reg_write  = rw;
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling
  // edge that follows each rising edge.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    applyStimulus(1'b0, 7'h00, 0, 0, 0, 1'b0, 0, 3'd0, 5'd0, 1'b0);

    @(negedge clk);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("reset out_result", out_result, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);

    // Plain ALU add.
    rst_n = 1'b1;
    applyStimulus(1'b1, 7'b0110011, 32'h0, 32'h0, 32'h7, 1'b0, 32'h0, 3'd0, 5'd3, 1'b1);
    stepCycle();
    checkOutput("add out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add out_result", out_result, 32'h7);
    checkOutput("add out_rd", {27'd0, out_rd}, 32'd3);
    checkOutput("add out_reg_write", {31'd0, out_reg_write}, 32'd1);
    checkOutput("add redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("add out_mem_read", {31'd0, out_mem_read}, 32'd0);

    // Taken BEQ, followed by a wrong-path bundle that must be squashed.
    applyStimulus(1'b1, 7'b1100011, 32'h100, 32'h20, 32'h0, 1'b1, 32'h0, 3'd0, 5'd0, 1'b0);
    stepCycle();
    checkOutput("beq redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("beq redirect_pc", redirect_pc, 32'h120);
    checkOutput("beq out_reg_write", {31'd0, out_reg_write}, 32'd0);
    checkOutput("beq out_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(1'b1, 7'b0110011, 32'h0, 32'h0, 32'h55, 1'b0, 32'h0, 3'd0, 5'd5, 1'b1);
    stepCycle();
    checkOutput("squash out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("squash redirect_valid", {31'd0, redirect_valid}, 32'd0);
    stepCycle();
    checkOutput("post-squash out_result", out_result, 32'h55);
    checkOutput("post-squash out_valid", {31'd0, out_valid}, 32'd1);

    // Not-taken branch: no redirect, no write.
    applyStimulus(1'b1, 7'b1100011, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0, 3'd1, 5'd6, 1'b1);
    stepCycle();
    checkOutput("bne redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("bne out_reg_write", {31'd0, out_reg_write}, 32'd0);
    checkOutput("bne out_funct3", {29'd0, out_funct3}, 32'd1);

    // JALR to a misaligned target (0x203 -> 0x202).
    applyStimulus(1'b1, 7'b1100111, 32'h40, 32'h0, 32'h203, 1'b0, 32'h0, 3'd0, 5'd1, 1'b1);
    stepCycle();
    checkOutput("jalr-mis out_misaligned", {31'd0, out_misaligned}, 32'd1);
    checkOutput("jalr-mis redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("jalr-mis out_reg_write", {31'd0, out_reg_write}, 32'd0);
    checkOutput("jalr-mis redirect_pc", redirect_pc, 32'h202);

    // JALR to an aligned target (0x205 -> 0x204).
    applyStimulus(1'b1, 7'b1100111, 32'h40, 32'h0, 32'h205, 1'b0, 32'h0, 3'd0, 5'd1, 1'b1);
    stepCycle();
    checkOutput("jalr redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("jalr redirect_pc", redirect_pc, 32'h204);
    checkOutput("jalr out_result", out_result, 32'h44);
    checkOutput("jalr out_reg_write", {31'd0, out_reg_write}, 32'd1);
    checkOutput("jalr out_misaligned", {31'd0, out_misaligned}, 32'd0);
    applyStimulus(1'b0, 7'h00, 0, 0, 0, 1'b0, 0, 3'd0, 5'd0, 1'b0);
    stepCycle();
    checkOutput("drain out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain redirect_valid", {31'd0, redirect_valid}, 32'd0);

    // Backpressure: JAL accepted, then a 3-cycle stall with in_valid high.
    out_ready = 1'b0;
    applyStimulus(1'b1, 7'b1101111, 32'h300, 32'h10, 32'h0, 1'b0, 32'h0, 3'd0, 5'd2, 1'b1);
    stepCycle();
    checkOutput("jal redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("jal redirect_pc", redirect_pc, 32'h310);
    checkOutput("jal out_result", out_result, 32'h304);
    checkOutput("jal in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, 7'b0110011, 32'h0, 32'h0, 32'h99, 1'b0, 32'h0, 3'd0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("stall redirect_valid", {31'd0, redirect_valid}, 32'd0);
      checkOutput("stall out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall out_result", out_result, 32'h304);
      checkOutput("stall out_rd", {27'd0, out_rd}, 32'd2);
      checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", {31'd0, in_ready}, 32'd1);
    stepCycle();
    checkOutput("drain+accept out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("drain+accept out_result", out_result, 32'h99);
    checkOutput("drain+accept out_rd", {27'd0, out_rd}, 32'd7);

    // Store to x0.
    applyStimulus(1'b1, 7'b0100011, 32'h0, 32'h0, 32'h1000, 1'b0, 32'hDEAD_BEEF, 3'd2, 5'd0, 1'b1);
    stepCycle();
    checkOutput("store out_mem_write", {31'd0, out_mem_write}, 32'd1);
    checkOutput("store out_store_data", out_store_data, 32'hDEAD_BEEF);
    checkOutput("store out_reg_write", {31'd0, out_reg_write}, 32'd0);
    checkOutput("store out_mem_read", {31'd0, out_mem_read}, 32'd0);

    // Load word.
    applyStimulus(1'b1, 7'b0000011, 32'h0, 32'h0, 32'h2000, 1'b0, 32'h0, 3'd2, 5'd4, 1'b1);
    stepCycle();
    checkOutput("load out_mem_read", {31'd0, out_mem_read}, 32'd1);
    checkOutput("load out_mem_write", {31'd0, out_mem_write}, 32'd0);
    checkOutput("load out_result", out_result, 32'h2000);
    checkOutput("load out_funct3", {29'd0, out_funct3}, 32'd2);
    checkOutput("load out_reg_write", {31'd0, out_reg_write}, 32'd1);

    // Reset mid-stall with a redirect pending.
    applyStimulus(1'b1, 7'b1101111, 32'h500, 32'h8, 32'h0, 1'b0, 32'h0, 3'd0, 5'd8, 1'b1);
    stepCycle();
    out_ready = 1'b0;
    checkOutput("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("pre-reset redirect_valid", {31'd0, redirect_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("async reset out_result", out_result, 32'd0);
    checkOutput("async reset redirect_pc", redirect_pc, 32'd0);
    checkOutput("async reset out_reg_write", {31'd0, out_reg_write}, 32'd0);

    // First accept after reset release.
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 7'b0110011, 32'h0, 32'h0, 32'h11, 1'b0, 32'h0, 3'd0, 5'd9, 1'b1);
    stepCycle();
    checkOutput("post-reset out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("post-reset out_result", out_result, 32'h11);
    checkOutput("post-reset redirect_valid", {31'd0, redirect_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
